// File: rtl/fft_n_rad2.sv
// Dual-stream streaming radix-2 DIT FFT. Each stream's frame is captured, then both frames
// pass through one shared pipelined butterfly network, and each spectrum is tagged by stream.

package fft_pkg;
  typedef struct packed {
    logic signed [31:0] r;
    logic signed [31:0] i;
  } complex_product_t;
endpackage

module fft_n_rad2
  import fft_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  complex_product_t         data_in_0,
  input  complex_product_t         data_in_1,
  output complex_product_t [N-1:0] fft_out,
  output logic                     out_valid,
  output logic                     output_mode
);
  localparam int unsigned S = $clog2(N);

  // Q1.14 cos(m*pi/32) for m = 0..16; every N <= 64 twiddle is taken from this table.
  function automatic logic signed [15:0] qcos(input int unsigned m);
    case (m)
      0:       return 16'sd16384;
      1:       return 16'sd16305;
      2:       return 16'sd16069;
      3:       return 16'sd15679;
      4:       return 16'sd15137;
      5:       return 16'sd14449;
      6:       return 16'sd13623;
      7:       return 16'sd12665;
      8:       return 16'sd11585;
      9:       return 16'sd10394;
      10:      return 16'sd9102;
      11:      return 16'sd7723;
      12:      return 16'sd6270;
      13:      return 16'sd4756;
      14:      return 16'sd3196;
      15:      return 16'sd1606;
      default: return 16'sd0;
    endcase
  endfunction

  function automatic logic signed [15:0] tw_re(input int unsigned k);
    return (k <= 16) ? qcos(k) : -qcos(32 - k);
  endfunction

  function automatic logic signed [15:0] tw_im(input int unsigned k);
    return (k <= 16) ? -qcos(16 - k) : -qcos(k - 16);
  endfunction

  function automatic int unsigned bitrev(input int unsigned v);
    int unsigned rev = 0;
    for (int b = 0; b < S; b++) rev |= ((v >> b) & 1) << (S - 1 - b);
    return rev;
  endfunction

  typedef enum logic [1:0] {StIdle, StInj0, StInj1} inj_state_e;

  inj_state_e       r_state, w_state_next;
  logic [S-1:0]     r_cnt;
  complex_product_t r_buf0 [N];
  complex_product_t r_buf1 [N];
  complex_product_t r_frm0 [N];
  complex_product_t r_frm1 [N];
  complex_product_t r_stg  [S][N];
  complex_product_t w_in   [S][N];
  complex_product_t w_bf   [S][N];
  logic [S-1:0]     r_vld, r_tag, w_vld_in, w_tag_in;
  logic             w_handoff, w_inj_valid, w_inj_tag;

  assign w_handoff = enable & (r_cnt == S'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      for (int i = 0; i < N; i++) begin
        r_buf0[i] <= '0;
        r_buf1[i] <= '0;
        r_frm0[i] <= '0;
        r_frm1[i] <= '0;
      end
    end else if (enable) begin
      r_buf0[r_cnt] <= data_in_0;
      r_buf1[r_cnt] <= data_in_1;
      r_cnt         <= r_cnt + S'(1);
      if (w_handoff) begin
        for (int i = 0; i < N - 1; i++) begin
          r_frm0[i] <= r_buf0[i];
          r_frm1[i] <= r_buf1[i];
        end
        r_frm0[N-1] <= data_in_0;
        r_frm1[N-1] <= data_in_1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Stream-0 frame goes in the cycle after hand-off, stream-1 frame the cycle after that.
  always_comb begin
    w_state_next = r_state;
    w_inj_valid  = 1'b0;
    w_inj_tag    = 1'b0;
    unique case (r_state)
      StIdle: if (w_handoff) w_state_next = StInj0;
      StInj0: begin
        w_inj_valid  = 1'b1;
        w_state_next = StInj1;
      end
      StInj1: begin
        w_inj_valid  = 1'b1;
        w_inj_tag    = 1'b1;
        w_state_next = w_handoff ? StInj0 : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_bitrev
    localparam int unsigned Src = bitrev(i);
    assign w_in[0][i] = w_inj_tag ? r_frm1[Src] : r_frm0[Src];
  end

  for (genvar s = 1; s < S; s++) begin : g_link
    for (genvar i = 0; i < N; i++) begin : g_elem
      assign w_in[s][i] = r_stg[s-1][i];
    end
  end

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int unsigned Half = 1 << s;
    for (genvar b = 0; b < N / 2; b++) begin : g_bfly
      localparam int unsigned Ia  = (b / Half) * 2 * Half + b % Half;
      localparam int unsigned Ib  = Ia + Half;
      localparam int unsigned K64 = (b % Half) * (32 >> s);
      localparam logic signed [47:0] Wr = 48'(tw_re(K64));
      localparam logic signed [47:0] Wi = 48'(tw_im(K64));
      logic signed [47:0] w_br, w_bi, w_pr, w_pi;
      logic signed [31:0] w_tr, w_ti;
      assign w_br = 48'($signed(w_in[s][Ib].r));
      assign w_bi = 48'($signed(w_in[s][Ib].i));
      assign w_pr = w_br * Wr - w_bi * Wi;
      assign w_pi = w_br * Wi + w_bi * Wr;
      assign w_tr = 32'(w_pr >>> 14);
      assign w_ti = 32'(w_pi >>> 14);
      assign w_bf[s][Ia] = {w_in[s][Ia].r + w_tr, w_in[s][Ia].i + w_ti};
      assign w_bf[s][Ib] = {w_in[s][Ia].r - w_tr, w_in[s][Ia].i - w_ti};
    end
  end

  assign w_vld_in = {r_vld[S-2:0], w_inj_valid};
  assign w_tag_in = {r_tag[S-2:0], w_inj_tag};

  // Data and tag load only behind a valid slot, so the output holds between spectra.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      r_tag <= '0;
      for (int s = 0; s < S; s++) begin
        for (int i = 0; i < N; i++) r_stg[s][i] <= '0;
      end
    end else begin
      r_vld <= w_vld_in;
      for (int s = 0; s < S; s++) begin
        if (w_vld_in[s]) begin
          r_tag[s] <= w_tag_in[s];
          for (int i = 0; i < N; i++) r_stg[s][i] <= w_bf[s][i];
        end
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_out
    assign fft_out[k] = r_stg[S-1][k];
  end

  assign out_valid   = r_vld[S-1];
  assign output_mode = r_tag[S-1];

endmodule

// File: tb/tb_fft_n_rad2.sv
// Directed bench for fft_n_rad2 (N=32): reset, impulse/DC spectra, latency, enable gap,
// back-to-back frames with twiddle-dependent bins, and reset mid-frame.
module tb_fft_n_rad2;
  import fft_pkg::*;

  localparam int N = 32;

  logic                     clk = 1'b0;
  logic                     reset, enable, out_valid, output_mode;
  complex_product_t         data_in_0, data_in_1;
  complex_product_t [N-1:0] fft_out;

  int               n_cmp = 0;
  int               n_err = 0;
  int               cyc = 0;
  complex_product_t s0 [N];
  complex_product_t s1 [N];
  logic [63:0]      spec0 [N];
  logic [63:0]      spec1 [N];
  int               e_m0, e_m1, e_low;

  // Stream-1 impulse at x[1] = 16384 gives X[k] = W^k (k<16) and -W^(k-16) (k>=16).
  int tw_bin [9] = '{0, 1, 3, 4, 8, 12, 16, 17, 24};
  int tw_re  [9] = '{16384, 16069, 13623, 11585, 0, -11585, -16384, -16069, 0};
  int tw_im  [9] = '{0, -3196, -9102, -11585, -16384, -11585, 0, 3196, 16384};

  fft_n_rad2 #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .data_in_0  (data_in_0),
    .data_in_1  (data_in_1),
    .fft_out    (fft_out),
    .out_valid  (out_valid),
    .output_mode(output_mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] cx(input int re, input int im);
    return {re, im};
  endfunction

  function automatic int nonzero_bins();
    int c = 0;
    for (int k = 0; k < N; k++) if (fft_out[k] != '0) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cx(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got (%0d,%0d) want (%0d,%0d)", tag, $signed(obs[63:32]),
             $signed(obs[31:0]), $signed(exp[63:32]), $signed(exp[31:0]));
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic load_imp_dc();
    for (int n = 0; n < N; n++) begin
      s0[n] = (n == 0) ? cx(100, 0) : '0;
      s1[n] = cx(10, 0);
    end
  endtask

  // Feeds one frame from s0/s1; fe/le are the edges accepting samples 0 and N-1.
  task automatic send_frame(input int gap_at, input int gap_len, output int fe, output int le,
                            output int vld_seen);
    vld_seen = 0;
    fe = -1;
    for (int n = 0; n < N; n++) begin
      if (n == gap_at) begin
        enable = 1'b0;
        repeat (gap_len) begin
          tick();
          vld_seen += int'(out_valid);
        end
      end
      enable    = 1'b1;
      data_in_0 = s0[n];
      data_in_1 = s1[n];
      tick();
      vld_seen += int'(out_valid);
      if (n == 0) fe = cyc;
    end
    le        = cyc;
    enable    = 1'b0;
    data_in_0 = '0;
    data_in_1 = '0;
  endtask

  task automatic collect();
    e_m0  = -1;
    e_m1  = -1;
    e_low = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid && !output_mode && e_m0 < 0) begin
        e_m0 = cyc;
        for (int i = 0; i < N; i++) spec0[i] = fft_out[i];
      end else if (out_valid && output_mode && e_m1 < 0) begin
        e_m1 = cyc;
        for (int i = 0; i < N; i++) spec1[i] = fft_out[i];
      end else if (!out_valid && e_m1 >= 0 && e_low < 0) begin
        e_low = cyc;
      end
    end
  endtask

  task automatic check_latency(input string pfx, input int t0);
    check_int({pfx, "_lat_mode0"}, e_m0 - t0, 5);
    check_int({pfx, "_lat_mode1"}, e_m1 - t0, 6);
    check_int({pfx, "_lat_low"}, e_low - t0, 7);
  endtask

  task automatic check_imp_dc(input string pfx);
    for (int k = 0; k < N; k++) begin
      check_cx($sformatf("%s_imp_bin%0d", pfx, k), spec0[k], cx(100, 0));
      check_cx($sformatf("%s_dc_bin%0d", pfx, k), spec1[k], (k == 0) ? cx(320, 0) : cx(0, 0));
    end
  endtask

  initial begin
    int fe, le, vs, np0, np1, nh, m1_last;
    int pe [3] = '{0, 0, 0};

    reset     = 1'b1;
    enable    = 1'b0;
    data_in_0 = '0;
    data_in_1 = '0;
    tick();
    tick();
    check_bit("rst_valid", out_valid, 1'b0);
    check_bit("rst_mode", output_mode, 1'b0);
    check_int("rst_nonzero_bins", nonzero_bins(), 0);
    reset = 1'b0;
    tick();

    load_imp_dc();
    send_frame(-1, 0, fe, le, vs);
    check_int("imp_early_valid", vs, 0);
    collect();
    check_latency("imp", le);
    check_int("imp_lat_from_start", e_m0 - fe, 36);
    check_imp_dc("imp");

    send_frame(16, 3, fe, le, vs);
    check_int("gap_early_valid", vs, 0);
    collect();
    check_latency("gap", le);
    check_int("gap_lat_from_start", e_m0 - fe, 39);
    check_imp_dc("gap");

    for (int n = 0; n < N; n++) begin
      s0[n] = cx((n % 2 == 0) ? 100 : -100, 0);
      s1[n] = (n == 1) ? cx(16384, 0) : '0;
    end
    np0     = 0;
    np1     = 0;
    nh      = 0;
    m1_last = -1;
    for (int c = 0; c < 3 * N + 20; c++) begin
      if (c < 3 * N) begin
        enable    = 1'b1;
        data_in_0 = s0[c % N];
        data_in_1 = s1[c % N];
      end else begin
        enable    = 1'b0;
        data_in_0 = '0;
        data_in_1 = '0;
      end
      tick();
      if (c == 0) fe = cyc;
      if (out_valid && !output_mode) begin
        if (np0 < 3) pe[np0] = cyc;
        np0++;
        for (int k = 0; k < N; k++)
          check_cx($sformatf("b2b_f%0d_alt_bin%0d", np0, k), fft_out[k],
                   (k == 16) ? cx(3200, 0) : cx(0, 0));
      end else if (out_valid && output_mode) begin
        np1++;
        m1_last = cyc;
        for (int j = 0; j < 9; j++)
          check_cx($sformatf("b2b_f%0d_tw_bin%0d", np1, tw_bin[j]), fft_out[tw_bin[j]],
                   cx(tw_re[j], tw_im[j]));
      end else if (m1_last >= 0 && cyc == m1_last + 10) begin
        nh++;
        check_bit($sformatf("hold%0d_mode", nh), output_mode, 1'b1);
        check_cx($sformatf("hold%0d_bin1", nh), fft_out[1], cx(16069, -3196));
        check_cx($sformatf("hold%0d_bin16", nh), fft_out[16], cx(-16384, 0));
      end
    end
    check_int("b2b_mode0_pulses", np0, 3);
    check_int("b2b_mode1_pulses", np1, 3);
    check_int("b2b_hold_checks", nh, 3);
    check_int("b2b_first_lat", pe[0] - fe, 36);
    check_int("b2b_spacing_1", pe[1] - pe[0], 32);
    check_int("b2b_spacing_2", pe[2] - pe[1], 32);

    for (int c = 0; c < 10; c++) begin
      enable    = 1'b1;
      data_in_0 = cx(int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)));
      data_in_1 = cx(int'($urandom_range(1, 1000)), 0);
      tick();
    end
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    check_bit("midrst_valid", out_valid, 1'b0);
    check_bit("midrst_mode", output_mode, 1'b0);
    check_int("midrst_nonzero_bins", nonzero_bins(), 0);
    reset = 1'b0;
    load_imp_dc();
    send_frame(-1, 0, fe, le, vs);
    check_int("midrst_early_valid", vs, 0);
    collect();
    check_latency("midrst", le);
    check_int("midrst_lat_from_start", e_m0 - fe, 36);
    check_imp_dc("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
